fp_div: RTL and testbench

Single-precision IEEE-754 floating-point divider. It is the inverse companion to the hard-DSP FP multiplier and handles the division steps in the force and energy pipelines (r⁻² and 1/r terms) that the DSP block cannot do natively. It uses an iterative radix-2 restoring divider with valid/ready handshakes on both sides. Denormals are flushed to zero, matching the DSP FP behaviour.

---
 rtl/fp_div_pkg.sv | 40 ++++
 rtl/fp_div_round.sv | 95 +++++++++
 rtl/fp_div.sv | 165 ++++++++++++++++
 tb/tb_fp_div.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// ============================================================================
// fp_div_pkg : shared constants, FSM states and operand classes for fp_div
// Rev 1.0
// ============================================================================
`default_nettype none

package fp_div_pkg;

  localparam int          EXP_BIAS = 127;
  localparam int          QBITS    = 27;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam int          EXP_MAX  = 255;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_ROUND  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CLS_ZERO   = 2'd0,
    CLS_INF    = 2'd1,
    CLS_NAN    = 2'd2,
    CLS_NORMAL = 2'd3
  } opclass_t;

  // Denormals (exponent 0, any mantissa) are treated as zero.
  function automatic opclass_t classify(input logic [7:0] e, input logic [22:0] m);
    if (e == 8'd0)
      return CLS_ZERO;
    else if (e == 8'hFF)
      return (m == 23'd0) ? CLS_INF : CLS_NAN;
    else
      return CLS_NORMAL;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_div_round.sv
// ============================================================================
// fp_div_round : normalize, round-to-nearest-even, range check, special cases
// Rev 1.0
// ============================================================================
`default_nettype none

module fp_div_round
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 10
) (
  input  logic [QBITS-1:0] q_i,
  input  logic             rem_nz_i,
  input  logic [7:0]       ea_i,
  input  logic [7:0]       eb_i,
  input  logic             sign_i,
  input  opclass_t         cls_n_i,
  input  opclass_t         cls_d_i,
  output logic [31:0]      result_o,
  output logic             dz_o,
  output logic             inv_o,
  output logic             ovf_o,
  output logic             unf_o
);

  localparam logic signed [EXP_W-1:0] BIAS = EXP_W'(EXP_BIAS);
  localparam logic signed [EXP_W-1:0] MAXE = EXP_W'(EXP_MAX);
  localparam logic signed [EXP_W-1:0] ONE  = EXP_W'(1);

  logic signed [EXP_W-1:0] exp_diff;
  logic signed [EXP_W-1:0] exp_raw;
  logic signed [EXP_W-1:0] exp_fin;
  logic [22:0]             frac;
  logic [22:0]             frac_rnd;
  logic                    rnd;
  logic                    sticky;
  logic                    inc;
  logic                    carry;
  logic                    is_ovf;
  logic                    is_unf;

  assign exp_diff = $signed({{(EXP_W-8){1'b0}}, ea_i}) - $signed({{(EXP_W-8){1'b0}}, eb_i});

  always_comb begin
    result_o = '0;
    dz_o     = 1'b0;
    inv_o    = 1'b0;
    ovf_o    = 1'b0;
    unf_o    = 1'b0;

    // The hidden bit is implied by the selected position, so only 23 fraction bits are kept.
    if (q_i[QBITS-1]) begin
      frac    = q_i[QBITS-2:3];
      rnd     = q_i[2];
      sticky  = (|q_i[1:0]) | rem_nz_i;
      exp_raw = exp_diff + BIAS;
    end else begin
      frac    = q_i[QBITS-3:2];
      rnd     = q_i[1];
      sticky  = q_i[0] | rem_nz_i;
      exp_raw = exp_diff + BIAS - ONE;
    end

    inc              = rnd & (sticky | frac[0]);
    {carry, frac_rnd} = {1'b0, frac} + {23'd0, inc};
    exp_fin          = exp_raw + $signed({{(EXP_W-1){1'b0}}, carry});
    is_ovf           = !exp_fin[EXP_W-1] && (exp_fin >= MAXE);
    is_unf           = exp_fin[EXP_W-1] || (exp_fin == '0);

    if (cls_n_i == CLS_NAN || cls_d_i == CLS_NAN ||
        (cls_n_i == CLS_ZERO && cls_d_i == CLS_ZERO) ||
        (cls_n_i == CLS_INF  && cls_d_i == CLS_INF)) begin
      result_o = QNAN;
      inv_o    = 1'b1;
    end else if (cls_d_i == CLS_ZERO && cls_n_i == CLS_NORMAL) begin
      result_o = {sign_i, 8'hFF, 23'd0};
      dz_o     = 1'b1;
    end else if (cls_n_i == CLS_INF) begin
      result_o = {sign_i, 8'hFF, 23'd0};
    end else if (cls_d_i == CLS_INF || cls_n_i == CLS_ZERO) begin
      result_o = {sign_i, 31'd0};
    end else if (is_ovf) begin
      result_o = {sign_i, 8'hFF, 23'd0};
      ovf_o    = 1'b1;
    end else if (is_unf) begin
      result_o = {sign_i, 31'd0};
      unf_o    = 1'b1;
    end else begin
      result_o = {sign_i, exp_fin[7:0], frac_rnd};
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_div.sv
// ============================================================================
// fp_div : iterative radix-2 restoring IEEE single divider, fixed 28-cycle latency
// Rev 1.0
// ============================================================================
`default_nettype none

module fp_div #(
  parameter int QBITS = 27,
  parameter int EXP_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] numer,
  input  logic [31:0] denom,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_dz,
  output logic        flag_inv,
  output logic        flag_ovf,
  output logic        flag_unf
);

  import fp_div_pkg::*;

  localparam logic [4:0] LAST_STEP = 5'(QBITS - 1);

  state_t           state_q;
  logic [4:0]       cnt_q;
  logic [24:0]      rem_q;
  logic [24:0]      rem_d;
  logic [QBITS-1:0] quo_q;
  logic [23:0]      mb_q;
  logic [7:0]       ea_q;
  logic [7:0]       eb_q;
  logic             sign_q;
  opclass_t         cls_n_q;
  opclass_t         cls_d_q;
  logic             out_valid_q;
  logic [31:0]      result_q;
  logic             dz_q;
  logic             inv_q;
  logic             ovf_q;
  logic             unf_q;

  logic             ge;
  logic [23:0]      ma_in;
  logic [23:0]      mb_in;
  logic [31:0]      rnd_result;
  logic             rnd_dz;
  logic             rnd_inv;
  logic             rnd_ovf;
  logic             rnd_unf;

  assign ma_in = {|numer[30:23], numer[22:0]};
  assign mb_in = {|denom[30:23], denom[22:0]};

  // Remainder stays below 2*mb, so after a successful subtract it fits in 24 bits.
  always_comb begin
    ge = (rem_q >= {1'b0, mb_q});
    if (ge)
      rem_d = {rem_q[23:0] - mb_q, 1'b0};
    else
      rem_d = {rem_q[23:0], 1'b0};
  end

  fp_div_round #(
    .EXP_W (EXP_W)
  ) u_round (
    .q_i      (quo_q),
    .rem_nz_i (|rem_q),
    .ea_i     (ea_q),
    .eb_i     (eb_q),
    .sign_i   (sign_q),
    .cls_n_i  (cls_n_q),
    .cls_d_i  (cls_d_q),
    .result_o (rnd_result),
    .dz_o     (rnd_dz),
    .inv_o    (rnd_inv),
    .ovf_o    (rnd_ovf),
    .unf_o    (rnd_unf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      mb_q        <= '0;
      ea_q        <= '0;
      eb_q        <= '0;
      sign_q      <= 1'b0;
      cls_n_q     <= CLS_ZERO;
      cls_d_q     <= CLS_ZERO;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      dz_q        <= 1'b0;
      inv_q       <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            rem_q   <= {1'b0, ma_in};
            quo_q   <= '0;
            mb_q    <= mb_in;
            ea_q    <= numer[30:23];
            eb_q    <= denom[30:23];
            sign_q  <= numer[31] ^ denom[31];
            cls_n_q <= classify(numer[30:23], numer[22:0]);
            cls_d_q <= classify(denom[30:23], denom[22:0]);
            cnt_q   <= '0;
            state_q <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          rem_q <= rem_d;
          quo_q <= {quo_q[QBITS-2:0], ge};
          if (cnt_q == LAST_STEP) begin
            cnt_q   <= '0;
            state_q <= S_ROUND;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        S_ROUND: begin
          result_q    <= rnd_result;
          dz_q        <= rnd_dz;
          inv_q       <= rnd_inv;
          ovf_q       <= rnd_ovf;
          unf_q       <= rnd_unf;
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            dz_q        <= 1'b0;
            inv_q       <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_dz   = dz_q;
  assign flag_inv  = inv_q;
  assign flag_ovf  = ovf_q;
  assign flag_unf  = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_div.sv
// ============================================================================
// tb_fp_div : scoreboard bench for fp_div, directed vectors plus random operands
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fp_div;

  localparam int PERIOD = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] numer = '0;
  logic [31:0] denom = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] result;
  logic        flag_dz;
  logic        flag_inv;
  logic        flag_ovf;
  logic        flag_unf;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;   // {dz, inv, ovf, unf}
    time         t;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_sent = 0;
  int   n_recv = 0;
  int   bp_mode = 0;    // 0: ready high, 1: random, 2: held low
  time  last_acc = 0;
  time  prev_acc = 0;

  fp_div dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .numer     (numer),
    .denom     (denom),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_dz   (flag_dz),
    .flag_inv  (flag_inv),
    .flag_ovf  (flag_ovf),
    .flag_unf  (flag_unf)
  );

  initial forever #(PERIOD/2) clk = ~clk;

  initial begin
    #(PERIOD * 100000);
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer quotient of the hidden-bit mantissas, then RNE by hand.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [7:0] ea, eb;
    logic       za, zb, ia, ib, na, nb, s;
    longint     ma, mb, q, r, m;
    int         e;
    logic       rb, st;
    ea = a[30:23];
    eb = b[30:23];
    za = (ea == 8'd0);
    zb = (eb == 8'd0);
    ia = (ea == 8'hFF) && (a[22:0] == 23'd0);
    ib = (eb == 8'hFF) && (b[22:0] == 23'd0);
    na = (ea == 8'hFF) && (a[22:0] != 23'd0);
    nb = (eb == 8'hFF) && (b[22:0] != 23'd0);
    s  = a[31] ^ b[31];
    if (na || nb || (za && zb) || (ia && ib)) return {4'b0100, 32'h7FC00000};
    if (zb && !ia) return {4'b1000, s, 8'hFF, 23'd0};
    if (ia) return {4'b0000, s, 8'hFF, 23'd0};
    if (ib || za) return {4'b0000, s, 31'd0};
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    q  = (ma * 64'd67108864) / mb;
    r  = (ma * 64'd67108864) % mb;
    if (q >= 64'd67108864) begin
      m  = q / 8;
      rb = q[2];
      st = (q % 4 != 0) || (r != 0);
      e  = int'(ea) - int'(eb) + 127;
    end else begin
      m  = q / 4;
      rb = q[1];
      st = (q % 2 != 0) || (r != 0);
      e  = int'(ea) - int'(eb) + 126;
    end
    if (rb && (st || m[0])) m = m + 1;
    if (m == 64'd16777216) begin
      m = 64'd8388608;
      e = e + 1;
    end
    if (e >= 255) return {4'b0010, s, 8'hFF, 23'd0};
    if (e <= 0) return {4'b0001, s, 31'd0};
    return {4'b0000, s, e[7:0], m[22:0]};
  endfunction

  task automatic send(input logic [31:0] n, input logic [31:0] d,
                      input logic [31:0] er, input logic [3:0] ef);
    int guard;
    guard = 0;
    @(negedge clk);
    numer    = n;
    denom    = d;
    in_valid = 1'b1;
    while (!in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_wait: got in_ready=0 expected 1 within 1000 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back('{er, ef, $time});
    prev_acc = last_acc;
    last_acc = $time;
    n_sent++;
    #1;
    in_valid = 1'b0;
    numer    = $urandom;
    denom    = $urandom;
  endtask

  task automatic send_model(input logic [31:0] n, input logic [31:0] d);
    logic [35:0] e;
    e = model(n, d);
    send(n, d, e[31:0], e[35:32]);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [31:0] rand_op();
    int          k;
    logic        s;
    logic [22:0] m;
    k = $urandom_range(0, 19);
    s = 1'($urandom);
    m = 23'($urandom);
    case (k)
      0:       return {s, 31'd0};
      1:       return {s, 8'hFF, 23'd0};
      2:       return {s, 8'hFF, m | 23'd1};
      3:       return {s, 8'h00, m};
      4, 5:    return {s, 8'($urandom_range(1, 254)), m};
      default: return {s, 8'($urandom_range(110, 144)), m};
    endcase
  endfunction

  // out_ready changes just after the rising edge so the monitor sees a settled value.
  initial forever begin
    @(posedge clk);
    #1;
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  initial begin
    logic pv;
    exp_t e;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !pv) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_output: got result %h expected no output", result);
        end else begin
          chk("latency", 32'($time - sb[0].t), 32'(28 * PERIOD + PERIOD / 2));
        end
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("flags", {28'd0, flag_dz, flag_inv, flag_ovf, flag_unf}, {28'd0, e.flg});
        n_recv++;
      end
      pv = out_valid;
    end
  end

  logic [31:0] dn [7] = '{32'h40C00000, 32'h3F800000, 32'hC0000000, 32'h3F800000,
                          32'h00000000, 32'h7F000000, 32'h00800000};
  logic [31:0] dd [7] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h00000000,
                          32'h00000000, 32'h3E800000, 32'h40000000};
  logic [31:0] dr [7] = '{32'h40400000, 32'h3EAAAAAB, 32'hC0000000, 32'h7F800000,
                          32'h7FC00000, 32'h7F800000, 32'h00000000};
  logic [3:0]  df [7] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

  initial begin
    #(PERIOD + 2);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_flags", {28'd0, flag_dz, flag_inv, flag_ovf, flag_unf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    bp_mode = 0;
    for (int i = 0; i < 7; i++) begin
      send(dn[i], dd[i], dr[i], df[i]);
      drain();
    end

    // Backpressure: DONE must hold its result and keep in_ready low.
    bp_mode = 2;
    send(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000);
    begin
      int g;
      g = 0;
      while (!out_valid && g < 100) begin
        @(negedge clk);
        g++;
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result", result, 32'h40400000);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    bp_mode = 0;
    drain();

    // in_valid during DIVIDE must not start a second operation.
    send(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000);
    repeat (5) @(negedge clk);
    numer    = 32'h3F800000;
    denom    = 32'h40400000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // Accept at k, DONE after k+28, IDLE after k+29, next accept at k+30.
    send(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000);
    send(32'hC0000000, 32'h3F800000, 32'hC0000000, 4'b0000);
    chk("accept_spacing", 32'((last_acc - prev_acc) / PERIOD), 32'd30);
    drain();

    // Asynchronous abort in the middle of DIVIDE.
    send(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000);
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_result", result, 32'd0);
    sb.delete();
    n_sent--;
    @(negedge clk);
    rst_n = 1'b1;
    send(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000);
    drain();

    bp_mode = 1;
    for (int i = 0; i < 150; i++) begin
      send_model(rand_op(), rand_op());
    end
    bp_mode = 0;
    drain();

    repeat (40) @(negedge clk);
    chk("outputs_received", 32'(n_recv), 32'(n_sent));
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
